dmem_access_ctrl: RTL

Sequencer for the data-memory access issued by the EX/MEM pipeline register. It converts the single-cycle MemRead/MemWrite strobes into a req/ack handshake with a multi-cycle data memory and holds the pipeline with `stall_o` until the access completes. It also returns load data to the MEM/WB stage and flags misaligned, conflicting and timed-out accesses. It sits between the EX/MEM register outputs and the data-memory port.

---
 rtl/dmem_access_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one EX/MEM data-memory access into a req/ack
// handshake with a multi-cycle memory. The pipeline is held with stall_o
// until the access completes. Misaligned, conflicting and timed-out accesses
// are flagged on err_o.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  logic access;
  logic conflict;
  logic misaligned;
  logic legal;
  logic timeout_hit;
  logic err_set;

  // Request decode: a conflict takes precedence over a misalignment.
  assign access      = mem_read_i | mem_write_i;
  assign conflict    = mem_read_i & mem_write_i;
  assign misaligned  = access & ~conflict & (addr_i[1:0] != 2'b00);
  assign legal       = access & ~conflict & (addr_i[1:0] == 2'b00);
  // An ack on the last allowed cycle wins over the timeout.
  assign timeout_hit = (cnt == CNT_LAST) & ~mem_ack_i;

  // State register.
  // NOTE: reset is sampled on the clock edge only (synchronous), so rst_i
  // belongs inside the edge-triggered block and never in its sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment before the case keeps every path assigned,
  // which is what prevents a latch from being inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (legal) state_nxt = BUSY;
      BUSY:    if (mem_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs: stall and the error request for the next cycle.
  always_comb begin
    stall_o = ((state == IDLE) && legal) || (state == BUSY);
    err_set = ((state == IDLE) && (conflict || misaligned)) ||
              ((state == BUSY) && timeout_hit);
  end

  // Registered datapath: latched request, timeout counter, load data, error.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      cnt         <= '0;
    end else begin
      err_o <= err_set;
      unique case (state)
        IDLE: begin
          if (legal) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= mem_write_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
            cnt         <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
          end else if (timeout_hit) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
